// File: rtl/si_tag_unpacker.sv
// Time-tag unpacker: drops the header beat (capturing its sequence number) and
// forwards payload beats as 64-bit tag lanes through a 2-entry skid buffer.
// Optional statistics counters are enabled with SI_UNPACK_STATS_EN.
module si_tag_unpacker #(
   parameter int DATA_WIDTH = 256,
   parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
   parameter int LANES      = DATA_WIDTH / 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                  s_axis_tlast,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [LANES-1:0]      m_axis_lane_valid,
   output logic                  m_axis_tlast,
   output logic [31:0]           m_axis_seq,
   output logic                  header_strobe,
   output logic                  misaligned,
   output logic                  dbg_state_o
`ifdef SI_UNPACK_STATS_EN
   ,
   output logic [47:0]           tag_count,
   output logic [31:0]           packet_count
`endif
);

   if (DATA_WIDTH != 256) begin : g_bad_width
      $error("si_tag_unpacker: DATA_WIDTH must be 256");
   end

   typedef enum logic {ST_HDR = 1'b0, ST_PAY = 1'b1} state_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [LANES-1:0]      mask;
      logic                  last;
      logic [31:0]           seq;
   } entry_t;

   state_t     state_q, state_d;
   entry_t     e0_q, e0_d, e1_q, e1_d, new_entry;
   logic       e0_valid_q, e0_valid_d, e1_valid_q, e1_valid_d;
   logic [31:0] seq_q, seq_d;
   logic       hdr_strobe_q, misaligned_q, misaligned_d;
   logic [LANES-1:0] lane_mask, lane_mixed;
   logic       s_fire, hdr_fire, pay_fire, push, pop;

   always_comb begin
      lane_mask  = '0;
      lane_mixed = '0;
      for (int i = 0; i < LANES; i++) begin
         lane_mask[i]  = &s_axis_tkeep[8*i +: 8];
         lane_mixed[i] = (|s_axis_tkeep[8*i +: 8]) && !lane_mask[i];
      end
   end

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_HDR;
      else        state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_HDR: if (hdr_fire && !s_axis_tlast) state_d = ST_PAY;
         ST_PAY: if (pay_fire && s_axis_tlast)  state_d = ST_HDR;
         default: state_d = ST_HDR;
      endcase
   end

   // FSM: outputs; ready depends on registers only, never on m_axis_tready
   always_comb begin
      s_axis_tready = (state_q == ST_HDR) || !e1_valid_q;
      s_fire        = s_axis_tvalid && s_axis_tready;
      hdr_fire      = s_fire && (state_q == ST_HDR);
      pay_fire      = s_fire && (state_q == ST_PAY);
   end

   assign push      = pay_fire && ((|lane_mask) || s_axis_tlast);
   assign pop       = e0_valid_q && m_axis_tready;
   assign new_entry = '{data: s_axis_tdata, mask: lane_mask, last: s_axis_tlast, seq: seq_q};

   always_comb begin
      e0_d       = e0_q;
      e1_d       = e1_q;
      e0_valid_d = e0_valid_q;
      e1_valid_d = e1_valid_q;
      if (e1_valid_q) begin
         if (pop) begin
            e0_d       = e1_q;
            e1_valid_d = 1'b0;
         end
      end else if (e0_valid_q) begin
         if (pop && push) begin
            e0_d = new_entry;
         end else if (pop) begin
            e0_valid_d = 1'b0;
         end else if (push) begin
            e1_d       = new_entry;
            e1_valid_d = 1'b1;
         end
      end else if (push) begin
         e0_d       = new_entry;
         e0_valid_d = 1'b1;
      end
   end

   assign seq_d        = hdr_fire ? s_axis_tdata[223:192] : seq_q;
   assign misaligned_d = misaligned_q || (pay_fire && (|lane_mixed));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e0_q         <= '0;
         e1_q         <= '0;
         e0_valid_q   <= 1'b0;
         e1_valid_q   <= 1'b0;
         seq_q        <= '0;
         hdr_strobe_q <= 1'b0;
         misaligned_q <= 1'b0;
      end else begin
         e0_q         <= e0_d;
         e1_q         <= e1_d;
         e0_valid_q   <= e0_valid_d;
         e1_valid_q   <= e1_valid_d;
         seq_q        <= seq_d;
         hdr_strobe_q <= hdr_fire;
         misaligned_q <= misaligned_d;
      end
   end

   assign m_axis_tvalid     = e0_valid_q;
   assign m_axis_tdata      = e0_q.data;
   assign m_axis_lane_valid = e0_q.mask;
   assign m_axis_tlast      = e0_q.last;
   assign m_axis_seq        = e0_q.seq;
   assign header_strobe     = hdr_strobe_q;
   assign misaligned        = misaligned_q;
   assign dbg_state_o       = state_q;

`ifdef SI_UNPACK_STATS_EN
   logic [47:0] tag_count_q, tag_pop;
   logic [31:0] packet_count_q;

   always_comb begin
      tag_pop = '0;
      for (int i = 0; i < LANES; i++) tag_pop = tag_pop + 48'(e0_q.mask[i]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_count_q    <= '0;
         packet_count_q <= '0;
      end else begin
         if (pop)      tag_count_q    <= tag_count_q + tag_pop;
         if (hdr_fire) packet_count_q <= packet_count_q + 32'd1;
      end
   end

   assign tag_count    = tag_count_q;
   assign packet_count = packet_count_q;
`endif

endmodule

// File: tb/tb_si_tag_unpacker.sv
// Randomized and directed bench for si_tag_unpacker with a queue-based scoreboard
// fed by a packet-level reference model.
module tb_si_tag_unpacker;

   localparam int EW = 256 + 4 + 1 + 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         s_axis_tvalid = 1'b0;
   logic         s_axis_tready;
   logic [255:0] s_axis_tdata = '0;
   logic [31:0]  s_axis_tkeep = '0;
   logic         s_axis_tlast = 1'b0;
   logic         m_axis_tvalid;
   logic         m_axis_tready = 1'b1;
   logic [255:0] m_axis_tdata;
   logic [3:0]   m_axis_lane_valid;
   logic         m_axis_tlast;
   logic [31:0]  m_axis_seq;
   logic         header_strobe;
   logic         misaligned;
   logic         dbg_state;
`ifdef SI_UNPACK_STATS_EN
   logic [47:0]  tag_count;
   logic [31:0]  packet_count;
`endif

   si_tag_unpacker dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_lane_valid(m_axis_lane_valid),
      .m_axis_tlast(m_axis_tlast), .m_axis_seq(m_axis_seq),
      .header_strobe(header_strobe), .misaligned(misaligned), .dbg_state_o(dbg_state)
`ifdef SI_UNPACK_STATS_EN
      , .tag_count(tag_count), .packet_count(packet_count)
`endif
   );

   // clock / reset
   always #5 clk = ~clk;

   // scoreboard and reference model state
   logic [EW-1:0] exp_q[$];
   int      checks = 0;
   int      errors = 0;
   bit      in_pkt = 1'b0;
   logic [31:0] m_seq = '0;
   bit      m_mis = 1'b0;
   int      m_hdr_cnt = 0;
   longint  tag_sum = 0;
   int      strobe_cnt = 0;
   int      rdy_mode = 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: one call per accepted input beat
   task automatic model_accept(input logic [255:0] d, input logic [31:0] k, input logic l);
      logic [3:0] mask;
      logic [7:0] b;
      if (!in_pkt) begin
         m_seq = d[223:192];
         m_hdr_cnt++;
         in_pkt = !l;
      end else begin
         mask = '0;
         for (int i = 0; i < 4; i++) begin
            b = k[8*i +: 8];
            if (b == 8'hFF) mask[i] = 1'b1;
            else if (b != 8'h00) m_mis = 1'b1;
         end
         if (mask != 4'd0 || l) exp_q.push_back({d, mask, l, m_seq});
         if (l) in_pkt = 1'b0;
      end
   endtask

   function automatic logic [255:0] rand_data();
      logic [255:0] d;
      for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
      return d;
   endfunction

   function automatic logic [255:0] hdr_data(input logic [31:0] seq);
      logic [255:0] d;
      d = rand_data();
      d[223:192] = seq;
      return d;
   endfunction

   function automatic logic [31:0] rand_keep();
      logic [31:0] k;
      int r;
      for (int i = 0; i < 4; i++) begin
         r = $urandom_range(0, 5);
         if (r <= 2)      k[8*i +: 8] = 8'hFF;
         else if (r == 3) k[8*i +: 8] = 8'h00;
         else             k[8*i +: 8] = 8'($urandom_range(1, 254));
      end
      return k;
   endfunction

   // driver: called at posedge+1, returns at posedge+1 after the accepting edge
   task automatic send_beat(input logic [255:0] d, input logic [31:0] k, input logic l);
      bit acc = 1'b0;
      int t = 0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      s_axis_tkeep  = k;
      s_axis_tlast  = l;
      while (!acc) begin
         @(negedge clk);
         acc = s_axis_tready;
         if (acc) model_accept(d, k, l);
         @(posedge clk);
         #1;
         t++;
         if (!acc && t > 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no s_axis_tready expected ready within 200 cycles");
            acc = 1'b1;
         end
      end
      s_axis_tvalid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int t = 0;
      rdy_mode = 1;
      while ((exp_q.size() != 0 || m_axis_tvalid) && t < 200) begin
         idle(1);
         t++;
      end
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      exp_q.delete();
      in_pkt = 1'b0;
      m_seq = '0;
      m_mis = 1'b0;
      m_hdr_cnt = 0;
      tag_sum = 0;
      strobe_cnt = 0;
   endtask

   task automatic chk_reset_state();
      chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("rst_m_tdata_zero", 64'(|m_axis_tdata), 64'd0);
      chk("rst_lane_valid", 64'(m_axis_lane_valid), 64'd0);
      chk("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
      chk("rst_m_seq", 64'(m_axis_seq), 64'd0);
      chk("rst_header_strobe", 64'(header_strobe), 64'd0);
      chk("rst_misaligned", 64'(misaligned), 64'd0);
      chk("rst_s_tready", 64'(s_axis_tready), 64'd1);
      chk("rst_state", 64'(dbg_state), 64'd0);
   endtask

   // m_axis_tready generator: 0 random, 1 always ready, 2 stalled
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       m_axis_tready = 1'($urandom_range(0, 1));
         2:       m_axis_tready = 1'b0;
         default: m_axis_tready = 1'b1;
      endcase
   end

   // monitor: pops and compares on every master handshake, checks hold stability
   logic [EW-1:0] held, obs, e;
   bit prev_stall = 1'b0;
   always @(negedge clk) begin
      obs = {m_axis_tdata, m_axis_lane_valid, m_axis_tlast, m_axis_seq};
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            checks++;
            if (!m_axis_tvalid || obs !== held) begin
               errors++;
               $display("FAIL hold_stable: got valid=%0b seq=%0h last=%0b lanes=%0h expected seq=%0h last=%0b lanes=%0h",
                        m_axis_tvalid, obs[31:0], obs[32], obs[36:33], held[31:0], held[32], held[36:33]);
            end
         end
         if (m_axis_tvalid && m_axis_tready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_beat: got seq=%0h lanes=%0h expected no output", obs[31:0], obs[36:33]);
            end else begin
               e = exp_q.pop_front();
               for (int i = 0; i < 4; i++) tag_sum += longint'(e[33+i]);
               if (obs !== e) begin
                  errors++;
                  $display("FAIL out_beat: got seq=%0h last=%0b lanes=%0h data[63:0]=%0h expected seq=%0h last=%0b lanes=%0h data[63:0]=%0h",
                           obs[31:0], obs[32], obs[36:33], obs[100:37], e[31:0], e[32], e[36:33], e[100:37]);
               end
            end
         end
         prev_stall = m_axis_tvalid && !m_axis_tready;
         held = obs;
         if (header_strobe) strobe_cnt++;
      end
   end

   initial begin
      int n;
      logic hl;
      do_reset();
      idle(3);
      rst_n = 1'b1;
      idle(1);
      chk_reset_state();

      // basic packet, seq 5, two full beats
      send_beat(hdr_data(32'h5), 32'hFFFF_FFFF, 1'b0);
      chk("header_strobe_pulse", 64'(header_strobe), 64'd1);
      send_beat(rand_data(), 32'hFFFF_FFFF, 1'b0);
      chk("latency_one_cycle", 64'(m_axis_tvalid), 64'd1);
      chk("header_strobe_once", 64'(header_strobe), 64'd0);
      send_beat(rand_data(), 32'hFFFF_FFFF, 1'b1);
      drain();
      chk("strobe_count_basic", 64'(strobe_cnt), 64'd1);

      // partial keep: whole lanes stay aligned, a split lane sets misaligned
      send_beat(hdr_data(32'h6), 32'hFFFF_FFFF, 1'b0);
      send_beat(rand_data(), 32'hFFFF_FFFF, 1'b0);
      send_beat(rand_data(), 32'h0000_FFFF, 1'b1);
      drain();
      chk("misaligned_clean", 64'(misaligned), 64'(m_mis));
      send_beat(hdr_data(32'h7), 32'hFFFF_FFFF, 1'b0);
      send_beat(rand_data(), 32'h0000_0FFF, 1'b1);
      drain();
      chk("misaligned_set", 64'(misaligned), 64'(m_mis));
      send_beat(hdr_data(32'h8), 32'hFFFF_FFFF, 1'b0);
      send_beat(rand_data(), 32'hFFFF_FFFF, 1'b1);
      drain();
      chk("misaligned_sticky", 64'(misaligned), 64'(m_mis));

      // backpressure: two beats buffered, then ready drops
      rdy_mode = 2;
      idle(1);
      send_beat(hdr_data(32'h11), 32'hFFFF_FFFF, 1'b0);
      send_beat(rand_data(), 32'hFFFF_FFFF, 1'b0);
      chk("bp_ready_after_1", 64'(s_axis_tready), 64'd1);
      send_beat(rand_data(), 32'hFFFF_FFFF, 1'b0);
      chk("bp_ready_after_2", 64'(s_axis_tready), 64'd0);
      idle(2);
      chk("bp_ready_held_low", 64'(s_axis_tready), 64'd0);
      rdy_mode = 1;
      for (int j = 0; j < 4; j++) send_beat(rand_data(), 32'hFFFF_FFFF, 1'(j == 3));
      drain();

      // header-only packet, then a normal one
      send_beat(hdr_data(32'h9), 32'hFFFF_FFFF, 1'b1);
      idle(2);
      chk("hdr_only_no_output", 64'(m_axis_tvalid), 64'd0);
      send_beat(hdr_data(32'hA), 32'hFFFF_FFFF, 1'b0);
      send_beat(rand_data(), 32'hFFFF_FFFF, 1'b1);
      drain();

      // dropped empty beat, and an empty tlast beat that is kept
      send_beat(hdr_data(32'hB), 32'hFFFF_FFFF, 1'b0);
      send_beat(rand_data(), 32'h0000_0000, 1'b0);
      send_beat(rand_data(), 32'hFFFF_FFFF, 1'b0);
      send_beat(rand_data(), 32'h0000_0000, 1'b1);
      drain();

      // reset mid-payload
      rdy_mode = 2;
      idle(1);
      send_beat(hdr_data(32'h20), 32'hFFFF_FFFF, 1'b0);
      send_beat(rand_data(), 32'hFFFF_FFFF, 1'b0);
      do_reset();
      #1;
      chk_reset_state();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      rdy_mode = 1;
      send_beat(hdr_data(32'h77), 32'hFFFF_FFFF, 1'b0);
      chk("post_reset_header_strobe", 64'(header_strobe), 64'd1);
      send_beat(rand_data(), 32'hFFFF_FFFF, 1'b1);
      drain();

      // three packets of two full beats
      for (int p = 0; p < 3; p++) begin
         send_beat(hdr_data(32'(32'h100 + p)), 32'hFFFF_FFFF, 1'b0);
         send_beat(rand_data(), 32'hFFFF_FFFF, 1'b0);
         send_beat(rand_data(), 32'hFFFF_FFFF, 1'b1);
      end
      drain();
`ifdef SI_UNPACK_STATS_EN
      chk("packet_count", 64'(packet_count), 64'(m_hdr_cnt));
      chk("tag_count", 64'(tag_count), 64'(tag_sum));
`endif

      // randomized traffic with random backpressure
      rdy_mode = 0;
      for (int p = 0; p < 40; p++) begin
         hl = 1'($urandom_range(0, 9) == 0);
         send_beat(hdr_data($urandom), 32'hFFFF_FFFF, hl);
         if (!hl) begin
            n = $urandom_range(1, 5);
            for (int j = 0; j < n; j++) begin
               send_beat(rand_data(), rand_keep(), 1'(j == n - 1));
               idle($urandom_range(0, 1));
            end
         end
      end
      drain();
      chk("misaligned_final", 64'(misaligned), 64'(m_mis));
      chk("strobe_count_final", 64'(strobe_cnt), 64'(m_hdr_cnt));
`ifdef SI_UNPACK_STATS_EN
      chk("packet_count_final", 64'(packet_count), 64'(m_hdr_cnt));
      chk("tag_count_final", 64'(tag_count), 64'(tag_sum));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/si_tag_unpacker.md
# si_tag_unpacker

Stage directly downstream of the time-tag packet header parser. It consumes validated 256-bit Time Tagger packets and discards the header beat, capturing its sequence number. It forwards payload beats as four 64-bit tag lanes with a per-lane valid mask. Outputs are registered behind a 2-entry skid buffer, so the block sustains full throughput with no combinational ready path from master to slave.

## Interface
- DATA_WIDTH, 256, stream width; only 256 is legal; any other value raises `$error` at elaboration.
- KEEP_WIDTH, (DATA_WIDTH+7)/8, byte-enable width.
- LANES, DATA_WIDTH/64, tag lanes per beat (4).

Ports:
- clk  input  1  sole clock; everything is synchronous to its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- s_axis_tvalid / s_axis_tready  input / output  1 / 1  slave handshake from the header parser.
- s_axis_tdata  input  256  packet data.
- s_axis_tkeep  input  32  byte enables.
- s_axis_tlast  input  1  end of packet.
- m_axis_tvalid / m_axis_tready  output / input  1 / 1  master handshake.
- m_axis_tdata  output  256  tag lanes; lane i = bits [64i+63:64i].
- m_axis_lane_valid  output  4  bit i set when lane i holds a complete tag.
- m_axis_tlast  output  1  last payload beat of the packet.
- m_axis_seq  output  32  sequence number of the packet the beat belongs to.
- header_strobe  output  1  one-cycle pulse when a header beat is consumed.
- misaligned  output  1  sticky; a lane was received with partial tkeep.

## Operation
- FSM states:
  - HDR (reset state).
  - PAY.
- HDR:
  - s_axis_tready=1.
  - On handshake, capture s_axis_tdata[223:192] into seq_reg and pulse header_strobe.
  - If tlast=0, go to PAY.
  - If tlast=1 (header-only packet), stay in HDR; nothing is emitted.
  - The header beat is never forwarded.
- PAY:
  - Each accepted beat is mapped to a lane mask: lane_valid[i] = &tkeep[8i+7:8i].
  - If a lane's tkeep bits are mixed (neither all 0 nor all 1), set misaligned and clear that lane's valid bit.
  - Push the beat (data, mask, tlast, seq_reg) into the skid buffer.
  - Exception: a beat with mask==0 and tlast=0 is dropped.
  - A beat with mask==0 and tlast=1 is still pushed, so tlast is preserved.
  - On an accepted tlast, return to HDR.
- Skid buffer:
  - Two entries.
  - Output register = entry 0.
  - Overflow register = entry 1.
- s_axis_tready in PAY = NOT entry1_valid (derived from registers only).
- misaligned clears only on reset.
- Reset mid-packet:
  - Buffer is emptied and FSM returns to HDR.
  - The remainder of an interrupted packet is treated as a new packet; its first beat is consumed as a header.

## Timing
- Reset values:
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_lane_valid=0, m_axis_tlast=0.
  - m_axis_seq=0, header_strobe=0, misaligned=0.
  - s_axis_tready=1, state=HDR, seq_reg=0, both buffer entries empty.
- Latency: a payload beat accepted at edge N is presented on m_axis at edge N+1.
- header_strobe is high exactly for the cycle after the header handshake edge.
- Throughput:
  - One beat per cycle while m_axis_tready=1.
  - The header beat costs one input cycle with no output bubble beyond it.
- Backpressure:
  - With m_axis_tready=0, the block accepts at most one more beat (into entry 1), then deasserts s_axis_tready on the next cycle.
  - Once asserted, m_axis_tvalid, m_axis_tdata, m_axis_lane_valid, m_axis_tlast and m_axis_seq hold stable until the handshake.
- Simultaneous push and pop:
  - With entry 0 full, entry 1 empty and m_axis_tready=1, the new beat moves straight into entry 0.
  - Occupancy is unchanged.
- m_axis_seq is sampled at push time, so a following header cannot overwrite it on buffered beats.

## Configuration
- SI_UNPACK_STATS_EN defined adds outputs:
  - tag_count[47:0]: adds popcount(lane_valid) on every master handshake; wraps modulo 2^48.
  - packet_count[31:0]: increments on every header handshake; wraps.
  - Both reset to 0.
- Without SI_UNPACK_STATS_EN, these ports and counters do not exist and all other behaviour is identical.

## Test plan
- Packet: header with seq 0x00000005, two full payload beats, tlast on the second → two output beats, lane_valid=4'hF, m_axis_seq=5, tlast on beat 2, header_strobe pulses once.
- Last payload beat with tkeep=32'h0000FFFF → lane_valid=4'b0011, misaligned stays 0. Repeat with tkeep=32'h00000FFF → lane_valid=4'b0001, misaligned=1 and stays set.
- m_axis_tready held low for 5 cycles during a 6-beat payload stream → s_axis_tready drops after exactly 2 beats are buffered; no beat lost or duplicated, and order is preserved after release.
- Header-only packet (tlast on header) with seq 9, followed by a normal packet with seq 10 → no output for the first packet; the second emits with m_axis_seq=10.
- Assert rst_n low for 1 cycle mid-payload → all outputs return to reset values immediately; the next beat accepted is treated as a header.
- With SI_UNPACK_STATS_EN: 3 packets of 2 full beats each → packet_count=3, tag_count=24.
